// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI responder and the sampling master FSM.
// Build option: ADC_SPI_LSBF_EN adds the LSB-first reply tail (LSB state).
package adc_spi_pkg;

  localparam int ADC_BITS  = 12;
  localparam int CMD_BITS  = 4;   // start, sgl, odd, msbf
  localparam int NULL_BITS = 1;   // null bit ahead of the data field
  localparam int CNT_W     = 4;

  // Counter value on the last bit of the MSB-first and LSB-first fields.
  localparam logic [CNT_W-1:0] DATA_LAST = 4'd11;
  localparam logic [CNT_W-1:0] LSB_LAST  = 4'd10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SGL  = 3'd1,
    ODD  = 3'd2,
    MSBF = 3'd3,
    NUL  = 3'd4,
    DATA = 3'd5,
`ifdef ADC_SPI_LSBF_EN
    LSB  = 3'd6,
`endif
    DONE = 3'd7
  } state_t;

  // a - b on a 13-bit intermediate; a negative result clamps to zero.
  function automatic logic [ADC_BITS-1:0] sat_sub(input logic [ADC_BITS-1:0] a,
                                                  input logic [ADC_BITS-1:0] b);
    logic [ADC_BITS:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[ADC_BITS]) begin
      sat_sub = {ADC_BITS{1'b0}};
    end else begin
      sat_sub = diff[ADC_BITS-1:0];
    end
  endfunction

endpackage

// File: rtl/adc_sample_select.sv
// Channel mux and saturating differential subtractor that form the reply word.
module adc_sample_select
  import adc_spi_pkg::*;
(
  input  logic                sgl,
  input  logic                odd,
  input  logic [ADC_BITS-1:0] ch0_data,
  input  logic [ADC_BITS-1:0] ch1_data,
  output logic [ADC_BITS-1:0] word
);

  // Single-ended picks a channel; differential subtracts in the odd-selected direction.
  always_comb begin
    word = {ADC_BITS{1'b0}};
    if (sgl) begin
      if (odd) begin
        word = ch1_data;
      end else begin
        word = ch0_data;
      end
    end else begin
      if (odd) begin
        word = sat_sub(ch1_data, ch0_data);
      end else begin
        word = sat_sub(ch0_data, ch1_data);
      end
    end
  end

endmodule

// File: rtl/adc_spi_responder.sv
// SPI ADC responder: decodes start/sgl/odd/msbf, then replies null bit + 12-bit word.
// Build option: ADC_SPI_LSBF_EN appends the LSB-first tail when msbf=0.
module adc_spi_responder
  import adc_spi_pkg::*;
(
  input  logic                sck,
  input  logic                reset,
  input  logic                cs_n,
  input  logic                sdi,
  input  logic [ADC_BITS-1:0] ch0_data,
  input  logic [ADC_BITS-1:0] ch1_data,
  output logic                sdo,
  output logic                sdo_oe,
  output logic                conv_done
);

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                sgl_r;
  logic [ADC_BITS-1:0] word_r;
  logic                sdo_r;
  logic                conv_done_r;
  logic [ADC_BITS-1:0] sel_word_s;
  logic [CNT_W-1:0]    data_idx_s;
  logic                clr_s;
`ifdef ADC_SPI_LSBF_EN
  logic                msbf_r;
  logic [CNT_W-1:0]    lsb_idx_s;
`endif

  // Deselect aborts a transaction exactly like reset does.
  assign clr_s     = reset | cs_n;
  assign sdo_oe    = ~cs_n;
  assign sdo       = sdo_r;
  assign conv_done = conv_done_r;

  // The odd bit is still on sdi during the ODD edge, so it feeds the mux directly.
  adc_sample_select u_sample_select (
    .sgl      (sgl_r),
    .odd      (sdi),
    .ch0_data (ch0_data),
    .ch1_data (ch1_data),
    .word     (sel_word_s)
  );

  // Bit index of the next MSB-first data bit (word[10] down to word[0]).
  always_comb begin
    data_idx_s = 4'd0;
    if (cnt_r < DATA_LAST) begin
      data_idx_s = DATA_LAST - 4'd1 - cnt_r;
    end else begin
      data_idx_s = 4'd0;
    end
  end

`ifdef ADC_SPI_LSBF_EN
  // Bit index of the next LSB-first tail bit (word[2] up to word[11]).
  always_comb begin
    lsb_idx_s = 4'd1;
    if (cnt_r < LSB_LAST) begin
      lsb_idx_s = cnt_r + 4'd2;
    end else begin
      lsb_idx_s = 4'd1;
    end
  end
`endif

  // Transaction FSM; every output bit is launched on the sck falling edge.
  always_ff @(negedge sck or posedge clr_s) begin
    if (clr_s) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      sgl_r       <= 1'b0;
`ifdef ADC_SPI_LSBF_EN
      msbf_r      <= 1'b0;
`endif
      word_r      <= 12'h000;
      sdo_r       <= 1'b0;
      conv_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sdo_r       <= 1'b0;
          conv_done_r <= 1'b0;
          if (sdi) begin
            state_r <= SGL;
          end else begin
            state_r <= IDLE;
          end
        end
        SGL: begin
          sgl_r   <= sdi;
          state_r <= ODD;
        end
        ODD: begin
          word_r  <= sel_word_s;
          state_r <= MSBF;
        end
        MSBF: begin
`ifdef ADC_SPI_LSBF_EN
          msbf_r  <= sdi;
`endif
          sdo_r   <= 1'b0;
          state_r <= NUL;
        end
        NUL: begin
          cnt_r   <= 4'd0;
          sdo_r   <= word_r[ADC_BITS-1];
          state_r <= DATA;
        end
        DATA: begin
          if (cnt_r == DATA_LAST) begin
            cnt_r <= 4'd0;
`ifdef ADC_SPI_LSBF_EN
            if (!msbf_r) begin
              sdo_r   <= word_r[1];
              state_r <= LSB;
            end else begin
              sdo_r       <= 1'b0;
              conv_done_r <= 1'b1;
              state_r     <= DONE;
            end
`else
            sdo_r       <= 1'b0;
            conv_done_r <= 1'b1;
            state_r     <= DONE;
`endif
          end else begin
            cnt_r <= cnt_r + 4'd1;
            sdo_r <= word_r[data_idx_s];
          end
        end
`ifdef ADC_SPI_LSBF_EN
        LSB: begin
          if (cnt_r == LSB_LAST) begin
            cnt_r       <= 4'd0;
            sdo_r       <= 1'b0;
            conv_done_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
            sdo_r <= word_r[lsb_idx_s];
          end
        end
`endif
        DONE: begin
          sdo_r       <= 1'b0;
          conv_done_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          cnt_r       <= 4'd0;
          sdo_r       <= 1'b0;
          conv_done_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder: stimulus queues the expected sdo/conv_done
// for every selected sck period, a monitor pops and compares whenever sdo_oe is high.
module tb_adc_spi_responder;

  logic        sck;
  logic        reset;
  logic        cs_n;
  logic        sdi;
  logic [11:0] ch0_data;
  logic [11:0] ch1_data;
  logic        sdo;
  logic        sdo_oe;
  logic        conv_done;

  int n_cmp;
  int n_err;

  typedef struct {
    logic  e_sdo;
    logic  e_cd;
    string tag;
  } exp_t;

  exp_t exp_q[$];

  adc_spi_responder dut (
    .sck       (sck),
    .reset     (reset),
    .cs_n      (cs_n),
    .sdi       (sdi),
    .ch0_data  (ch0_data),
    .ch1_data  (ch1_data),
    .sdo       (sdo),
    .sdo_oe    (sdo_oe),
    .conv_done (conv_done)
  );

  // Free-running SPI clock; edges while deselected must be ignored by the DUT.
  initial sck = 1'b0;
  always #10 sck = ~sck;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  // One selected sck period: drive sdi after the rising edge, queue the expected
  // outputs that the following falling edge must produce.
  task automatic slot(input logic b, input logic e_sdo, input logic e_cd, input string tag);
    exp_t e;
    @(posedge sck);
    #2;
    cs_n = 1'b0;
    sdi  = b;
    e.e_sdo = e_sdo;
    e.e_cd  = e_cd;
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle_gap();
    repeat (3) begin
      @(posedge sck);
      #2;
      sdi = ~sdi;
    end
    sdi = 1'b0;
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(posedge sck);
      #1;
      if (sdo_oe === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: actual sdo=%b conv_done=%b required no reply", sdo, conv_done);
        end else begin
          e = exp_q.pop_front();
          check({e.tag, " sdo"}, sdo, e.e_sdo);
          check({e.tag, " conv_done"}, conv_done, e.e_cd);
        end
      end
    end
  endtask

  task automatic run_txn(input string tag, input int lead, input logic sgl, input logic odd,
                         input logic msbf, input logic [11:0] c0, input logic [11:0] c1,
                         input logic [11:0] exp_word, input int abort_after, input logic rst_in_nul);
    exp_t e;
    logic tail;
    tail = 1'b0;
`ifdef ADC_SPI_LSBF_EN
    tail = ~msbf;
`endif
    ch0_data = c0;
    ch1_data = c1;
    for (int i = 0; i < lead; i++) slot(1'b0, 1'b0, 1'b0, $sformatf("%s lead%0d", tag, i));
    slot(1'b1, 1'b0, 1'b0, {tag, " start"});
    slot(sgl,  1'b0, 1'b0, {tag, " sgl"});
    slot(odd,  1'b0, 1'b0, {tag, " odd"});
    slot(msbf, 1'b0, 1'b0, {tag, " null"});
    // The word is latched by now; later channel changes must not leak into the reply.
    ch0_data = ~c0;
    ch1_data = ~c1;
    if (rst_in_nul) begin
      @(posedge sck);
      #2;
      reset = 1'b1;
      e.e_sdo = 1'b0;
      e.e_cd  = 1'b0;
      e.tag   = {tag, " in_reset"};
      exp_q.push_back(e);
      #1;
      check({tag, " rst sdo"}, sdo, 1'b0);
      check({tag, " rst conv_done"}, conv_done, 1'b0);
      check({tag, " rst sdo_oe"}, sdo_oe, 1'b1);
      @(posedge sck);
      #2;
      reset = 1'b0;
      cs_n  = 1'b1;
      idle_gap();
      return;
    end
    for (int i = 0; i < 12; i++) begin
      slot(1'b0, exp_word[11-i], 1'b0, $sformatf("%s d%0d", tag, 11 - i));
      if (i + 1 == abort_after) begin
        @(posedge sck);
        #2;
        cs_n = 1'b1;
        #1;
        check({tag, " abort sdo_oe"}, sdo_oe, 1'b0);
        check({tag, " abort sdo"}, sdo, 1'b0);
        check({tag, " abort conv_done"}, conv_done, 1'b0);
        idle_gap();
        return;
      end
    end
    if (tail) begin
      for (int i = 1; i < 12; i++) slot(1'b0, exp_word[i], 1'b0, $sformatf("%s l%0d", tag, i));
    end
    slot(1'b0, 1'b0, 1'b1, {tag, " done"});
    slot(1'b0, 1'b0, 1'b0, {tag, " idle"});
    @(posedge sck);
    #2;
    cs_n = 1'b1;
    idle_gap();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    cs_n     = 1'b1;
    sdi      = 1'b0;
    ch0_data = 12'h000;
    ch1_data = 12'h000;
    #5;
    check("reset sdo", sdo, 1'b0);
    check("reset conv_done", conv_done, 1'b0);
    check("reset sdo_oe deselected", sdo_oe, 1'b0);
    cs_n = 1'b0;
    #1;
    check("reset sdo_oe selected", sdo_oe, 1'b1);
    check("reset sdo selected", sdo, 1'b0);
    cs_n = 1'b1;
    #1;
    reset = 1'b0;
    fork
      monitor_loop();
    join_none

    run_txn("v030",      0, 1'b1, 1'b0, 1'b1, 12'hABC, 12'h123, 12'hABC, -1, 1'b0);
    run_txn("v031a",     0, 1'b0, 1'b0, 1'b1, 12'h100, 12'h200, 12'h000, -1, 1'b0);
    run_txn("v031b",     0, 1'b0, 1'b1, 1'b1, 12'h100, 12'h200, 12'h100, -1, 1'b0);
    run_txn("v032",      3, 1'b1, 1'b0, 1'b1, 12'hABC, 12'h123, 12'hABC, -1, 1'b0);
    run_txn("v033abort", 0, 1'b1, 1'b0, 1'b1, 12'hABC, 12'h123, 12'hABC,  5, 1'b0);
    run_txn("v033after", 0, 1'b1, 1'b0, 1'b1, 12'hABC, 12'h123, 12'hABC, -1, 1'b0);
    run_txn("v034",      0, 1'b1, 1'b1, 1'b0, 12'h5A5, 12'h801, 12'h801, -1, 1'b0);
    run_txn("v034msbf",  0, 1'b1, 1'b1, 1'b1, 12'h5A5, 12'h801, 12'h801, -1, 1'b0);
    run_txn("diff_max",  0, 1'b0, 1'b0, 1'b1, 12'hFFF, 12'h001, 12'hFFE, -1, 1'b0);
    run_txn("diff_eq",   0, 1'b0, 1'b1, 1'b1, 12'h555, 12'h555, 12'h000, -1, 1'b0);
    run_txn("v035rst",   0, 1'b1, 1'b0, 1'b1, 12'hABC, 12'h123, 12'hABC, -1, 1'b1);
    run_txn("v035after", 0, 1'b1, 1'b1, 1'b1, 12'h3C5, 12'h7E1, 12'h7E1, -1, 1'b0);

    repeat (4) @(posedge sck);
    #3;
    check("scoreboard drained", exp_q.size() == 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 sck input 1: SPI clock from the sampling master, idle low; all responder state changes on its falling edge.
REQ-002 reset input 1: reset, asynchronous, active-high.
REQ-003 cs_n input 1: active-low chip select; high is an asynchronous clear of the transaction FSM, ORed with reset.
REQ-004 sdi input 1: command bits from the master, sampled on sck falling edge.
REQ-005 ch0_data input 12: channel-0 sample value, unsigned.
REQ-006 ch1_data input 12: channel-1 sample value, unsigned.
REQ-007 sdo output 1: serial reply to the master, registered, updated on sck falling edge.
REQ-008 sdo_oe output 1: sdo drive enable, equal to ~cs_n (combinational); the top level tri-states sdo when low.
REQ-009 conv_done output 1: high for exactly one sck period after the last reply bit is driven.

Function
REQ-010 The FSM SHALL have states IDLE, SGL, ODD, MSBF, NUL, DATA, LSB, DONE, advancing only on sck falling edge.
REQ-011 IDLE: the start bit is sdi=1; sdi=0 keeps the FSM in IDLE, so leading zeros are ignored.
REQ-012 SGL -> ODD -> MSBF: capture sgl, odd and msbf flags, one bit per falling edge.
REQ-013 On the falling edge in ODD, latch the 12-bit reply word per REQ-014 and REQ-015; later input changes do not affect the transaction.
REQ-014 sgl=1: word = ch0_data if odd=0, else ch1_data.
REQ-015 sgl=0 (differential): word = ch0_data-ch1_data if odd=0, else ch1_data-ch0_data; a negative result saturates to 0x000 (13-bit intermediate).
REQ-016 On the falling edge in MSBF, go to NUL and drive sdo=0 (null bit).
REQ-017 DATA: drive word[11] down to word[0] on 12 consecutive falling edges; a 4-bit counter runs 0..11 and wraps to 0 on exit.
REQ-018 After word[0], go to LSB if msbf=0 and LSBF_EN is defined; otherwise go to DONE.
REQ-019 LSB: drive word[1] up to word[11] on 11 consecutive falling edges, then go to DONE.
REQ-020 DONE: conv_done=1 and sdo=0; the next falling edge returns to IDLE.
REQ-021 Outside NUL, DATA and LSB, sdo SHALL be 0.
REQ-022 cs_n rising mid-transaction: the FSM returns to IDLE immediately and the counter, flags and conv_done clear; no partial reply resumes.
REQ-023 sck edges while cs_n is high SHALL have no effect.

Reset
REQ-024 On reset: state=IDLE, counter=0, sdo=0, conv_done=0, flags=0, word=0x000.
REQ-025 Reset asserted mid-transaction SHALL abort identically to REQ-022; sdo_oe still follows cs_n.

Configuration
REQ-026 Macro ADC_SPI_LSBF_EN defined: the LSB state and the msbf=0 LSB-first tail are present.
REQ-027 Macro ADC_SPI_LSBF_EN undefined: the LSB state is absent, the msbf flag is ignored, and DATA always goes to DONE.

Structure
REQ-028 Package adc_spi_pkg SHALL hold the state enum, ADC_BITS=12 and the command bit-count constants shared with the master FSM.
REQ-029 Sub-module adc_sample_select SHALL be the combinational channel mux plus saturating differential subtractor (REQ-014, REQ-015).

Verification
REQ-030 cs_n low, sdi=1,1,0,1 (start, sgl=1, odd=0, msbf=1), ch0=0xABC -> sdo = 0 then 101010111100, then conv_done pulse.
REQ-031 sgl=0, ch0=0x100, ch1=0x200: odd=0 -> reply 0x000; odd=1 -> reply 0x100.
REQ-032 Three leading sdi=0 bits before the start bit -> reply identical to REQ-030, delayed by 3 sck.
REQ-033 cs_n raised after the 5th data bit -> sdo_oe=0 at once; the next full transaction returns the correct 0xABC.
REQ-034 With ADC_SPI_LSBF_EN, msbf=0, ch1=0x801 (sgl=1, odd=1) -> 100000000001 then 00000000001, 23 bits total; without the macro, only 12 bits.
REQ-035 reset pulsed during the NUL state -> all outputs take reset values; the following transaction is correct.
